// File: rtl/rfp_sample_buffer.sv
// RF power sample ring buffer with PPS tagging and a WISHBONE control/pop/window port.
// Optional build macro RFP_BUF_OVERWRITE_EN: when full, new samples overwrite the oldest word.
module rfp_sample_buffer #(
    parameter int NUM_CH     = 12,
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int ADR_W      = DEPTH_LOG2 + 3
) (
    input  logic                wbc_clk_i,
    input  logic                wbc_rst_i,
    input  logic                wbc_cyc_i,
    input  logic                wbc_stb_i,
    input  logic                wbc_we_i,
    input  logic [ADR_W-1:0]    wbc_adr_i,
    input  logic [31:0]         wbc_dat_i,
    input  logic [3:0]          wbc_sel_i,
    output logic [31:0]         wbc_dat_o,
    output logic                wbc_ack_o,
    output logic                wbc_err_o,
    output logic                wbc_rty_o,
    input  logic                smp_valid_i,
    input  logic [3:0]          smp_ch_i,
    input  logic [SAMPLE_W-1:0] smp_dat_i,
    output logic                smp_ready_o,
    input  logic                pps_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    localparam cnt_t       FULL_CNT = cnt_t'(DEPTH);
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_rd_q;

    logic        enable_q, enable_d, clear_q, clear_d, ready_q, ready_d;
    ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    logic        overflow_q, overflow_d, pps_pending_q, pps_pending_d;
    logic [31:0] drop_cnt_q, drop_cnt_d, pps_cnt_q, pps_cnt_d;
    logic [2:0]  pps_sync_q;
    logic        req_q, ack_q, we_q, win_q, pop_hit_q;
    logic        we_d, win_d, pop_hit_d;
    logic [2:0]  reg_idx_q, reg_idx_d;
    logic [31:0] dat_q, dat_d, reg_rd_s, word_s;
    ptr_t        mem_raddr_s;
    logic        start_s, reg_sel_s, ctrl_wr_s, pop_s, pps_rise_s, accept_s, bad_ch_s;
    logic        full_s, ok_s, store_s, ovw_s, drop_full_s;
    logic        unused_s;

    assign wbc_err_o   = 1'b0;
    assign wbc_rty_o   = 1'b0;
    assign wbc_ack_o   = ack_q;
    assign wbc_dat_o   = dat_q;
    assign smp_ready_o = ready_q;
    assign unused_s    = ^{wbc_sel_i, wbc_adr_i[1:0], wbc_dat_i[31:2]};

    // Bus decode, sample accept and overflow policy for the current cycle.
    always_comb begin
        start_s     = wbc_cyc_i && wbc_stb_i && !req_q && !ack_q;
        reg_sel_s   = start_s && !wbc_adr_i[ADR_W-1];
        ctrl_wr_s   = reg_sel_s && wbc_we_i && (wbc_adr_i[4:2] == 3'd0);
        pop_s       = reg_sel_s && !wbc_we_i && (wbc_adr_i[4:2] == 3'd6) && (count_q != cnt_t'(0));
        pps_rise_s  = pps_sync_q[1] && !pps_sync_q[2];
        accept_s    = smp_valid_i && ready_q;
        bad_ch_s    = accept_s && ({1'b0, smp_ch_i} >= NUM_CH_L);
        full_s      = (count_q == FULL_CNT);
        ok_s        = accept_s && !bad_ch_s;
`ifdef RFP_BUF_OVERWRITE_EN
        store_s     = ok_s;
        ovw_s       = ok_s && full_s && !pop_s;
        drop_full_s = 1'b0;
`else
        store_s     = ok_s && (!full_s || pop_s);
        ovw_s       = 1'b0;
        drop_full_s = ok_s && full_s && !pop_s;
`endif
        word_s      = {pps_pending_q || pps_rise_s, 3'b000, smp_ch_i, 24'(smp_dat_i)};
        if (wbc_adr_i[ADR_W-1]) begin
            mem_raddr_s = ptr_t'(wbc_adr_i[ADR_W-2:2]);
        end else begin
            mem_raddr_s = rd_ptr_q;
        end
    end

    // Next-state for the buffer bookkeeping and the bus pipeline.
    always_comb begin
        enable_d      = enable_q;
        clear_d       = ctrl_wr_s && wbc_dat_i[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        pps_pending_d = pps_pending_q;
        pps_cnt_d     = pps_cnt_q + (pps_rise_s ? 32'd1 : 32'd0);
        if (ctrl_wr_s) begin
            enable_d = wbc_dat_i[0];
        end else begin
            enable_d = enable_q;
        end
        ready_d = enable_d && !clear_d;
        if (clear_q) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            overflow_d    = 1'b0;
            drop_cnt_d    = 32'd0;
            pps_pending_d = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + (store_s ? ptr_t'(1) : ptr_t'(0));
            rd_ptr_d   = rd_ptr_q + ((pop_s || ovw_s) ? ptr_t'(1) : ptr_t'(0));
            if (store_s && !pop_s && !ovw_s) begin
                count_d = count_q + cnt_t'(1);
            end else if (pop_s && !store_s) begin
                count_d = count_q - cnt_t'(1);
            end else begin
                count_d = count_q;
            end
            overflow_d = overflow_q || ovw_s || drop_full_s;
            if ((bad_ch_s || drop_full_s) && (drop_cnt_q != 32'hFFFF_FFFF)) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (store_s) begin
                pps_pending_d = 1'b0;
            end else if (pps_rise_s) begin
                pps_pending_d = 1'b1;
            end else begin
                pps_pending_d = pps_pending_q;
            end
        end
        if (start_s) begin
            we_d      = wbc_we_i;
            win_d     = wbc_adr_i[ADR_W-1];
            reg_idx_d = wbc_adr_i[4:2];
            pop_hit_d = pop_s;
        end else begin
            we_d      = we_q;
            win_d     = win_q;
            reg_idx_d = reg_idx_q;
            pop_hit_d = pop_hit_q;
        end
    end

    // Register read mux, evaluated in the cycle after the strobe is taken.
    always_comb begin
        case (reg_idx_q)
            3'd0:    reg_rd_s = {31'd0, enable_q};
            3'd1:    reg_rd_s = {13'd0, overflow_q, full_s, (count_q == cnt_t'(0)), 16'(count_q)};
            3'd2:    reg_rd_s = 32'(wr_ptr_q);
            3'd3:    reg_rd_s = 32'(rd_ptr_q);
            3'd4:    reg_rd_s = pps_cnt_q;
            3'd5:    reg_rd_s = drop_cnt_q;
            3'd6:    reg_rd_s = pop_hit_q ? mem_rd_q : 32'd0;
            default: reg_rd_s = 32'd0;
        endcase
        if (req_q && !we_q) begin
            dat_d = win_q ? mem_rd_q : reg_rd_s;
        end else begin
            dat_d = 32'd0;
        end
    end

    // Sample RAM: write-at-accept, read-first so a same-cycle pop sees the oldest word.
    always_ff @(posedge wbc_clk_i) begin
        if (store_s) begin
            mem_q[wr_ptr_q] <= word_s;
        end
        mem_rd_q <= mem_q[mem_raddr_s];
    end

    // State registers with synchronous reset.
    always_ff @(posedge wbc_clk_i) begin
        if (wbc_rst_i) begin
            enable_q      <= 1'b0;
            clear_q       <= 1'b0;
            ready_q       <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= 32'd0;
            pps_cnt_q     <= 32'd0;
            pps_pending_q <= 1'b0;
            pps_sync_q    <= 3'b000;
            req_q         <= 1'b0;
            ack_q         <= 1'b0;
            we_q          <= 1'b0;
            win_q         <= 1'b0;
            reg_idx_q     <= 3'd0;
            pop_hit_q     <= 1'b0;
            dat_q         <= 32'd0;
        end else begin
            enable_q      <= enable_d;
            clear_q       <= clear_d;
            ready_q       <= ready_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            pps_cnt_q     <= pps_cnt_d;
            pps_pending_q <= pps_pending_d;
            pps_sync_q    <= {pps_sync_q[1:0], pps_i};
            req_q         <= start_s;
            ack_q         <= req_q;
            we_q          <= we_d;
            win_q         <= win_d;
            reg_idx_q     <= reg_idx_d;
            pop_hit_q     <= pop_hit_d;
            dat_q         <= dat_d;
        end
    end
endmodule
